quant_zigzag: RTL

Downstream stage of `dct_2d`. On the `block_done` pulse it captures the 8x8 block of signed 52-bit fixed-point DCT coefficients. It quantizes each coefficient against the standard JPEG luminance table and streams the 64 results in zigzag order, one per accepted transfer, over a valid/ready handshake into the entropy coder.

---
 rtl/jpeg_pkg.sv | 75 +++++++
 rtl/quant_round.sv | 40 ++++
 rtl/quant_zigzag.sv | 114 +++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// JPEG constants shared by the quantizer stages:
// luminance table, reciprocals, zigzag ROM, types.
package jpeg_pkg;

  typedef logic signed [51:0] coef_t;
  typedef logic signed [11:0] qcoef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] Q_LUMA [8][8] = '{
    '{8'd16, 8'd11, 8'd10, 8'd16,
      8'd24, 8'd40, 8'd51, 8'd61},
    '{8'd12, 8'd12, 8'd14, 8'd19,
      8'd26, 8'd58, 8'd60, 8'd55},
    '{8'd14, 8'd13, 8'd16, 8'd24,
      8'd40, 8'd57, 8'd69, 8'd56},
    '{8'd14, 8'd17, 8'd22, 8'd29,
      8'd51, 8'd87, 8'd80, 8'd62},
    '{8'd18, 8'd22, 8'd37, 8'd56,
      8'd68, 8'd109, 8'd103, 8'd77},
    '{8'd24, 8'd35, 8'd55, 8'd64,
      8'd81, 8'd104, 8'd113, 8'd92},
    '{8'd49, 8'd64, 8'd78, 8'd87,
      8'd103, 8'd121, 8'd120, 8'd101},
    '{8'd72, 8'd92, 8'd95, 8'd98,
      8'd112, 8'd100, 8'd103, 8'd99}
  };

  // round(65536 / Q_LUMA)
  localparam logic [16:0] RECIP_LUMA [8][8] = '{
    '{17'd4096, 17'd5958, 17'd6554, 17'd4096,
      17'd2731, 17'd1638, 17'd1285, 17'd1074},
    '{17'd5461, 17'd5461, 17'd4681, 17'd3449,
      17'd2521, 17'd1130, 17'd1092, 17'd1192},
    '{17'd4681, 17'd5041, 17'd4096, 17'd2731,
      17'd1638, 17'd1150, 17'd950, 17'd1170},
    '{17'd4681, 17'd3855, 17'd2979, 17'd2260,
      17'd1285, 17'd753, 17'd819, 17'd1057},
    '{17'd3641, 17'd2979, 17'd1771, 17'd1170,
      17'd964, 17'd601, 17'd636, 17'd851},
    '{17'd2731, 17'd1872, 17'd1192, 17'd1024,
      17'd809, 17'd630, 17'd580, 17'd712},
    '{17'd1337, 17'd1024, 17'd840, 17'd753,
      17'd636, 17'd542, 17'd546, 17'd649},
    '{17'd910, 17'd712, 17'd690, 17'd669,
      17'd585, 17'd655, 17'd636, 17'd662}
  };

  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

endpackage

// File: rtl/quant_round.sv
// Combinational quantizer: coef * recip, round half
// away from zero, saturate to +/-(2^(OUT_W-1)-1).
module quant_round
  import jpeg_pkg::*;
#(
  parameter int IN_FRAC = 24,
  parameter int OUT_W   = 12,
  parameter int CW      = 52
) (
  input  logic signed [CW-1:0]    coef,
  input  logic        [16:0]      recip,
  output logic signed [OUT_W-1:0] q
);

  localparam int PW = CW + 18;
  localparam int S  = 16 + IN_FRAC;

  localparam logic [PW-1:0] HALF =
    {{(PW-1){1'b0}}, 1'b1} << (S - 1);
  localparam logic [PW-1:0] MAXV =
    {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  logic signed [PW-1:0] prod;
  logic        [PW-1:0] mag;
  logic        [PW-1:0] rnd;
  logic        [OUT_W-1:0] qmag;
  logic                 neg;

  // magnitude rounding keeps the result symmetric about zero
  always_comb begin
    prod = PW'(coef) * PW'($signed({1'b0, recip}));
    neg  = prod[PW-1];
    mag  = neg ? $unsigned(-prod) : $unsigned(prod);
    rnd  = (mag + HALF) >> S;
    qmag = (rnd > MAXV) ? MAXV[OUT_W-1:0]
                        : rnd[OUT_W-1:0];
    q    = neg ? -$signed(qmag) : $signed(qmag);
  end

endmodule

// File: rtl/quant_zigzag.sv
// Captures a DCT block, quantizes it and streams it
// in zigzag order over a valid/ready handshake.
module quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int IN_FRAC = 24,
  parameter int OUT_W   = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          block_done,
  input  logic signed [7:0][7:0][51:0]  dct_block_out,
  output logic                          busy,
  output logic                          drop_err,
  output logic                          coef_valid,
  input  logic                          coef_ready,
  output logic signed [OUT_W-1:0]       coef_data,
  output logic        [5:0]             coef_index,
  output logic                          coef_last
);

  state_t state_q;
  state_t state_d;

  logic [5:0] zz_q;
  logic       cap;
  logic       load;

  logic [7:0][7:0][51:0] blk_q;

  logic [2:0]              row;
  logic [2:0]              col;
  logic signed [OUT_W-1:0] q;

  assign busy = (state_q != ST_IDLE);
  assign row  = ZZ_ROW[zz_q];
  assign col  = ZZ_COL[zz_q];

  quant_round #(
    .IN_FRAC (IN_FRAC),
    .OUT_W   (OUT_W),
    .CW      (52)
  ) u_round (
    .coef  ($signed(blk_q[row][col])),
    .recip (RECIP_LUMA[row][col]),
    .q     (q)
  );

  // coefficient buffer, contents irrelevant until captured
  always_ff @(posedge clk) begin
    if (cap) blk_q <= dct_block_out;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state, capture and load strobes
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (block_done) begin
          cap     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!coef_valid || coef_ready) begin
          load = 1'b1;
          if (zz_q == 6'd63) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (coef_valid && coef_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // zigzag counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    zz_q <= 6'd0;
    else if (cap)  zz_q <= 6'd0;
    else if (load) zz_q <= zz_q + 6'd1;
  end

  // output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err   <= 1'b0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_index <= 6'd0;
      coef_last  <= 1'b0;
    end else begin
      drop_err <= block_done && (state_q != ST_IDLE);
      if (load) begin
        coef_valid <= 1'b1;
        coef_data  <= q;
        coef_index <= zz_q;
        coef_last  <= (zz_q == 6'd63);
      end else if (coef_ready) begin
        coef_valid <= 1'b0;
      end
    end
  end

endmodule
